// File: rtl/xbar_pkg.sv
// Shared sizing constants and tag/pointer types for the channel reorder buffer.
package xbar_pkg;
   localparam int DATA_W     = 128;
   localparam int ROB_DEPTH  = 8;
   localparam int ROB_PTR_W  = 3;
   localparam int CH_ID_W    = 2;
   localparam int NUM_BANKS  = 4;
   localparam int BANK_IDX_W = 2;

   typedef logic [ROB_PTR_W-1:0] rob_tag_t;
   // One extra MSB distinguishes full from empty when the indices match.
   typedef logic [ROB_PTR_W:0]   rob_ptr_t;
endpackage

// File: rtl/spw_buffer.sv
// Per-bank return data store: one synchronous write port, one asynchronous read port.
module spw_buffer #(
   parameter int DEPTH = 8,
   parameter int W     = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/xbar_rob_retire.sv
// Channel reorder buffer: in-order tag allocation, out-of-order capture of bank
// returns for CHANNEL_ID, strictly in-order retirement to the channel.
module xbar_rob_retire
   import xbar_pkg::*;
#(
   parameter logic [CH_ID_W-1:0] CHANNEL_ID = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 alloc_valid_i,
   output logic                 alloc_ready_o,
   output logic [ROB_PTR_W-1:0] alloc_rob_num_o,
   input  logic                 bank0_sc_xbar_valid_i,
   output logic                 bank0_sc_xbar_allowIn_o,
   input  logic [CH_ID_W-1:0]   bank0_sc_xbar_ch_id_i,
   input  logic [ROB_PTR_W-1:0] bank0_sc_xbar_rob_num_i,
   input  logic [DATA_W-1:0]    bank0_sc_xbar_data_i,
   input  logic                 bank1_sc_xbar_valid_i,
   output logic                 bank1_sc_xbar_allowIn_o,
   input  logic [CH_ID_W-1:0]   bank1_sc_xbar_ch_id_i,
   input  logic [ROB_PTR_W-1:0] bank1_sc_xbar_rob_num_i,
   input  logic [DATA_W-1:0]    bank1_sc_xbar_data_i,
   input  logic                 bank2_sc_xbar_valid_i,
   output logic                 bank2_sc_xbar_allowIn_o,
   input  logic [CH_ID_W-1:0]   bank2_sc_xbar_ch_id_i,
   input  logic [ROB_PTR_W-1:0] bank2_sc_xbar_rob_num_i,
   input  logic [DATA_W-1:0]    bank2_sc_xbar_data_i,
   input  logic                 bank3_sc_xbar_valid_i,
   output logic                 bank3_sc_xbar_allowIn_o,
   input  logic [CH_ID_W-1:0]   bank3_sc_xbar_ch_id_i,
   input  logic [ROB_PTR_W-1:0] bank3_sc_xbar_rob_num_i,
   input  logic [DATA_W-1:0]    bank3_sc_xbar_data_i,
   output logic                 ch_resp_valid_o,
   input  logic                 ch_resp_ready_i,
   output logic [ROB_PTR_W-1:0] ch_resp_rob_num_o,
   output logic [DATA_W-1:0]    ch_resp_data_o,
   output logic                 err_o
);
   rob_ptr_t head, tail;
   rob_tag_t head_idx, tail_idx;
   logic [ROB_DEPTH-1:0]                 alloc_v, done;
   logic [ROB_DEPTH-1:0][BANK_IDX_W-1:0] src;
   logic full, empty, alloc_fire, retire, wr_err;

   logic [NUM_BANKS-1:0] wr_fire, wr_legal, wr_dup;
   rob_tag_t             wr_tag  [NUM_BANKS];
   logic [DATA_W-1:0]    wr_data [NUM_BANKS];
   logic [DATA_W-1:0]    rd_data [NUM_BANKS];

   assign wr_fire[0] = bank0_sc_xbar_valid_i & (bank0_sc_xbar_ch_id_i == CHANNEL_ID);
   assign wr_fire[1] = bank1_sc_xbar_valid_i & (bank1_sc_xbar_ch_id_i == CHANNEL_ID);
   assign wr_fire[2] = bank2_sc_xbar_valid_i & (bank2_sc_xbar_ch_id_i == CHANNEL_ID);
   assign wr_fire[3] = bank3_sc_xbar_valid_i & (bank3_sc_xbar_ch_id_i == CHANNEL_ID);
   assign wr_tag[0]  = bank0_sc_xbar_rob_num_i;
   assign wr_tag[1]  = bank1_sc_xbar_rob_num_i;
   assign wr_tag[2]  = bank2_sc_xbar_rob_num_i;
   assign wr_tag[3]  = bank3_sc_xbar_rob_num_i;
   assign wr_data[0] = bank0_sc_xbar_data_i;
   assign wr_data[1] = bank1_sc_xbar_data_i;
   assign wr_data[2] = bank2_sc_xbar_data_i;
   assign wr_data[3] = bank3_sc_xbar_data_i;

   // Entries are reserved at allocation, so returns are never back-pressured.
   assign bank0_sc_xbar_allowIn_o = rst_i;
   assign bank1_sc_xbar_allowIn_o = rst_i;
   assign bank2_sc_xbar_allowIn_o = rst_i;
   assign bank3_sc_xbar_allowIn_o = rst_i;

   assign head_idx   = head[ROB_PTR_W-1:0];
   assign tail_idx   = tail[ROB_PTR_W-1:0];
   assign empty      = (head == tail);
   assign full       = (head[ROB_PTR_W] != tail[ROB_PTR_W]) & (head_idx == tail_idx);
   assign alloc_ready_o   = !full;
   assign alloc_rob_num_o = tail_idx;
   assign alloc_fire      = alloc_valid_i & alloc_ready_o;

   assign ch_resp_valid_o   = !empty & done[head_idx];
   assign ch_resp_rob_num_o = head_idx;
   assign ch_resp_data_o    = rd_data[src[head_idx]];
   assign retire            = ch_resp_valid_o & ch_resp_ready_i;

   // A tag hit by two banks in one cycle is ambiguous, so every colliding write is dropped.
   always_comb begin
      wr_dup   = '0;
      wr_legal = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         for (int j = 0; j < NUM_BANKS; j++) begin
            if (j != k && wr_fire[j] && wr_fire[k] && wr_tag[j] == wr_tag[k]) wr_dup[k] = 1'b1;
         end
         wr_legal[k] = wr_fire[k] & alloc_v[wr_tag[k]] & !done[wr_tag[k]] & !wr_dup[k];
      end
   end

   assign wr_err = |(wr_fire & ~wr_legal);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         head    <= '0;
         tail    <= '0;
         alloc_v <= '0;
         done    <= '0;
         src     <= '0;
         err_o   <= 1'b0;
      end else begin
         if (alloc_fire) begin
            alloc_v[tail_idx] <= 1'b1;
            tail              <= tail + rob_ptr_t'(1);
         end
         if (retire) begin
            alloc_v[head_idx] <= 1'b0;
            done[head_idx]    <= 1'b0;
            head              <= head + rob_ptr_t'(1);
         end
         for (int k = 0; k < NUM_BANKS; k++) begin
            if (wr_legal[k]) begin
               done[wr_tag[k]] <= 1'b1;
               src[wr_tag[k]]  <= BANK_IDX_W'(k);
            end
         end
         if (wr_err) err_o <= 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_buf
      spw_buffer #(.DEPTH(ROB_DEPTH), .W(DATA_W), .AW(ROB_PTR_W)) u_buf (
         .clk_i   (clk_i),
         .we_i    (wr_legal[g]),
         .waddr_i (wr_tag[g]),
         .wdata_i (wr_data[g]),
         .raddr_i (head_idx),
         .rdata_o (rd_data[g])
      );
   end
endmodule

// File: tb/tb_xbar_rob_retire.sv
// Directed self-checking bench for the channel reorder buffer.
module tb_xbar_rob_retire;
   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         alloc_valid_i = 1'b0;
   logic         alloc_ready_o;
   logic [2:0]   alloc_rob_num_o;
   logic         bv   [4];
   logic [1:0]   bch  [4];
   logic [2:0]   btag [4];
   logic [127:0] bdat [4];
   logic [3:0]   allow_in;
   logic         ch_resp_valid_o;
   logic         ch_resp_ready_i = 1'b0;
   logic [2:0]   ch_resp_rob_num_o;
   logic [127:0] ch_resp_data_o;
   logic         err_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   xbar_rob_retire #(.CHANNEL_ID(2'd0)) dut (
      .clk_i                   (clk_i),
      .rst_i                   (rst_i),
      .alloc_valid_i           (alloc_valid_i),
      .alloc_ready_o           (alloc_ready_o),
      .alloc_rob_num_o         (alloc_rob_num_o),
      .bank0_sc_xbar_valid_i   (bv[0]),
      .bank0_sc_xbar_allowIn_o (allow_in[0]),
      .bank0_sc_xbar_ch_id_i   (bch[0]),
      .bank0_sc_xbar_rob_num_i (btag[0]),
      .bank0_sc_xbar_data_i    (bdat[0]),
      .bank1_sc_xbar_valid_i   (bv[1]),
      .bank1_sc_xbar_allowIn_o (allow_in[1]),
      .bank1_sc_xbar_ch_id_i   (bch[1]),
      .bank1_sc_xbar_rob_num_i (btag[1]),
      .bank1_sc_xbar_data_i    (bdat[1]),
      .bank2_sc_xbar_valid_i   (bv[2]),
      .bank2_sc_xbar_allowIn_o (allow_in[2]),
      .bank2_sc_xbar_ch_id_i   (bch[2]),
      .bank2_sc_xbar_rob_num_i (btag[2]),
      .bank2_sc_xbar_data_i    (bdat[2]),
      .bank3_sc_xbar_valid_i   (bv[3]),
      .bank3_sc_xbar_allowIn_o (allow_in[3]),
      .bank3_sc_xbar_ch_id_i   (bch[3]),
      .bank3_sc_xbar_rob_num_i (btag[3]),
      .bank3_sc_xbar_data_i    (bdat[3]),
      .ch_resp_valid_o         (ch_resp_valid_o),
      .ch_resp_ready_i         (ch_resp_ready_i),
      .ch_resp_rob_num_o       (ch_resp_rob_num_o),
      .ch_resp_data_o          (ch_resp_data_o),
      .err_o                   (err_o)
   );

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_banks();
      for (int k = 0; k < 4; k++) begin
         bv[k] = 1'b0; bch[k] = 2'd0; btag[k] = 3'd0; bdat[k] = '0;
      end
   endtask

   task automatic bank_wr(input int k, input logic [1:0] ch, input logic [2:0] t, input logic [127:0] d);
      bv[k] = 1'b1; bch[k] = ch; btag[k] = t; bdat[k] = d;
   endtask

   task automatic do_reset();
      alloc_valid_i   = 1'b0;
      ch_resp_ready_i = 1'b0;
      idle_banks();
      rst_i = 1'b0;
      @(posedge clk_i);
      #3 rst_i = 1'b1;
      #1;
   endtask

   task automatic alloc_seq(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         alloc_valid_i = 1'b1;
         #1 check_val("alloc_tag", alloc_rob_num_o, 128'((first + i) % 8));
         cyc();
      end
      alloc_valid_i = 1'b0;
   endtask

   initial begin
      idle_banks();
      #2;
      check_val("rst_ready", alloc_ready_o, 1);
      check_val("rst_valid", ch_resp_valid_o, 0);
      check_val("rst_allowin", allow_in, 0);
      check_val("rst_err", err_o, 0);
      check_val("rst_tag", alloc_rob_num_o, 0);
      do_reset();
      check_val("run_allowin", allow_in, 4'hf);

      // in-order returns from a single bank
      alloc_seq(3, 0);
      ch_resp_ready_i = 1'b1;
      bank_wr(0, 2'd0, 3'd0, 128'hD0);
      #1 check_val("io_pre_valid", ch_resp_valid_o, 0);
      cyc();
      for (int t = 0; t < 3; t++) begin
         if (t < 2) bank_wr(0, 2'd0, 3'(t + 1), 128'hD0 + 128'(t + 1));
         else idle_banks();
         #1 check_val("io_valid", ch_resp_valid_o, 1);
         check_val("io_tag", ch_resp_rob_num_o, 128'(t));
         check_val("io_data", ch_resp_data_o, 128'hD0 + 128'(t));
         cyc();
      end
      #1 check_val("io_drained", ch_resp_valid_o, 0);

      // out-of-order completions must wait for the head
      do_reset();
      alloc_seq(4, 0);
      ch_resp_ready_i = 1'b1;
      idle_banks(); bank_wr(2, 2'd0, 3'd3, 128'h103);
      #1 check_val("ro_hold3", ch_resp_valid_o, 0); cyc();
      idle_banks(); bank_wr(1, 2'd0, 3'd1, 128'h101);
      #1 check_val("ro_hold1", ch_resp_valid_o, 0); cyc();
      idle_banks(); bank_wr(3, 2'd0, 3'd2, 128'h102);
      #1 check_val("ro_hold2", ch_resp_valid_o, 0); cyc();
      idle_banks(); bank_wr(0, 2'd0, 3'd0, 128'h100);
      #1 check_val("ro_hold0", ch_resp_valid_o, 0); cyc();
      idle_banks();
      for (int t = 0; t < 4; t++) begin
         #1 check_val("ro_valid", ch_resp_valid_o, 1);
         check_val("ro_tag", ch_resp_rob_num_o, 128'(t));
         check_val("ro_data", ch_resp_data_o, 128'h100 + 128'(t));
         cyc();
      end
      #1 check_val("ro_drained", ch_resp_valid_o, 0);

      // four parallel writes, then again after the tail wraps past 4
      do_reset();
      alloc_seq(4, 0);
      for (int k = 0; k < 4; k++) bank_wr(k, 2'd0, 3'(k), 128'(k + 1));
      cyc();
      idle_banks();
      ch_resp_ready_i = 1'b1;
      for (int t = 0; t < 4; t++) begin
         #1 check_val("par0_tag", ch_resp_rob_num_o, 128'(t));
         check_val("par0_data", ch_resp_data_o, 128'(t + 1));
         cyc();
      end
      ch_resp_ready_i = 1'b0;
      alloc_seq(4, 4);
      for (int k = 0; k < 4; k++) bank_wr(k, 2'd0, 3'(k + 4), 128'hA + 128'(k));
      cyc();
      idle_banks();
      ch_resp_ready_i = 1'b1;
      for (int t = 0; t < 4; t++) begin
         #1 check_val("par_valid", ch_resp_valid_o, 1);
         check_val("par_tag", ch_resp_rob_num_o, 128'(t + 4));
         check_val("par_data", ch_resp_data_o, 128'hA + 128'(t));
         cyc();
      end
      ch_resp_ready_i = 1'b0;
      #1 check_val("par_drained", ch_resp_valid_o, 0);
      check_val("par_next_tag", alloc_rob_num_o, 0);
      check_val("par_ready", alloc_ready_o, 1);
      check_val("par_err", err_o, 0);

      // full, retire while full, wrap
      do_reset();
      alloc_seq(8, 0);
      #1 check_val("full_ready", alloc_ready_o, 0);
      bank_wr(0, 2'd0, 3'd0, 128'h55);
      alloc_valid_i = 1'b1;
      cyc();
      idle_banks();
      ch_resp_ready_i = 1'b1;
      #1 check_val("full_resp_valid", ch_resp_valid_o, 1);
      check_val("full_retire_ready", alloc_ready_o, 0);
      cyc();
      #1 check_val("wrap_ready", alloc_ready_o, 1);
      check_val("wrap_tag", alloc_rob_num_o, 0);
      cyc();
      #1 check_val("refull_ready", alloc_ready_o, 0);
      alloc_valid_i   = 1'b0;
      ch_resp_ready_i = 1'b0;

      // back-pressure holds head stable
      do_reset();
      alloc_seq(1, 0);
      bank_wr(1, 2'd0, 3'd0, 128'hBEEF);
      cyc();
      idle_banks();
      for (int i = 0; i < 5; i++) begin
         #1 check_val("bp_valid", ch_resp_valid_o, 1);
         check_val("bp_data", ch_resp_data_o, 128'hBEEF);
         cyc();
      end
      ch_resp_ready_i = 1'b1;
      #1 check_val("bp_release", ch_resp_valid_o, 1);
      cyc();
      #1 check_val("bp_retired", ch_resp_valid_o, 0);
      check_val("bp_err", err_o, 0);

      // write to unallocated tag
      do_reset();
      alloc_seq(2, 0);
      #1 check_val("e1_pre", err_o, 0);
      bank_wr(0, 2'd0, 3'd5, 128'h5);
      cyc();
      idle_banks();
      #1 check_val("e1_err", err_o, 1);
      check_val("e1_valid", ch_resp_valid_o, 0);
      cyc();
      #1 check_val("e1_sticky", err_o, 1);

      // write to an already-done tag
      do_reset();
      alloc_seq(1, 0);
      bank_wr(0, 2'd0, 3'd0, 128'h1111);
      cyc();
      idle_banks();
      #1 check_val("e2_pre", err_o, 0);
      bank_wr(1, 2'd0, 3'd0, 128'h2222);
      cyc();
      idle_banks();
      #1 check_val("e2_err", err_o, 1);
      check_val("e2_valid", ch_resp_valid_o, 1);
      check_val("e2_data", ch_resp_data_o, 128'h1111);

      // two banks colliding on one tag
      do_reset();
      alloc_seq(2, 0);
      bank_wr(0, 2'd0, 3'd1, 128'h31);
      bank_wr(2, 2'd0, 3'd1, 128'h32);
      cyc();
      idle_banks();
      #1 check_val("e3_err", err_o, 1);
      bank_wr(0, 2'd0, 3'd0, 128'h30);
      ch_resp_ready_i = 1'b1;
      cyc();
      idle_banks();
      #1 check_val("e3_head0", ch_resp_valid_o, 1);
      cyc();
      #1 check_val("e3_tag1_not_done", ch_resp_valid_o, 0);
      ch_resp_ready_i = 1'b0;

      // foreign channel is ignored
      do_reset();
      alloc_seq(1, 0);
      bank_wr(0, 2'd2, 3'd0, 128'h99);
      bank_wr(3, 2'd1, 3'd4, 128'h98);
      cyc();
      idle_banks();
      #1 check_val("fc_err", err_o, 0);
      check_val("fc_valid", ch_resp_valid_o, 0);
      bank_wr(0, 2'd0, 3'd0, 128'h97);
      cyc();
      idle_banks();
      #1 check_val("fc_own_valid", ch_resp_valid_o, 1);
      check_val("fc_own_data", ch_resp_data_o, 128'h97);

      // asynchronous reset between edges
      do_reset();
      alloc_seq(2, 0);
      bank_wr(0, 2'd0, 3'd0, 128'h77);
      cyc();
      idle_banks();
      #1 check_val("ar_pre_valid", ch_resp_valid_o, 1);
      #2 rst_i = 1'b0;
      #1 check_val("ar_valid", ch_resp_valid_o, 0);
      check_val("ar_ready", alloc_ready_o, 1);
      check_val("ar_tag", alloc_rob_num_o, 0);
      check_val("ar_allowin", allow_in, 0);
      #1 rst_i = 1'b1;
      cyc();
      #1 check_val("ar_post_tag", alloc_rob_num_o, 0);
      check_val("ar_post_valid", ch_resp_valid_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
